// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch with in-order tagging, redirect flush and a DEPTH-entry decode FIFO.
// Latency: data_ok to out_valid is 1 cycle, or 0 cycles into an empty FIFO when FETCH_BYPASS_EN is defined.
// Backpressure: requests are issued only while FIFO space covers every live in-flight request.
module inst_fetch_queue #(
  parameter int                DEPTH           = 8,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'hbfc00000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_req,
  output logic [ADDR_W-1:0]          inst_addr,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [DATA_W-1:0]          inst_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  output logic                       out_adel,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {S_FETCH, S_ADEL_WAIT, S_IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [OW-1:0]     outstanding, discard, live, outstanding_nxt;
  logic [ADDR_W-1:0] tag_q [MAX_OUTSTANDING];
  logic [TW-1:0]     tag_wr, tag_rd;
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [DEPTH-1:0]  mem_adel;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic accept, rsp_live, fifo_empty, bypass, pop, data_push, adel_push, push, credit_ok;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] push_inst;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  assign live      = outstanding - discard;
  assign credit_ok = (32'(count) + 32'(live)) < 32'(DEPTH);
  // Gated by reset so the bus sees no request while the block is held in reset.
  assign inst_req  = !reset && !redirect_valid && (state == S_FETCH) && credit_ok &&
                     (outstanding < OW'(MAX_OUTSTANDING));
  assign inst_addr = pc;
  assign accept    = inst_req && inst_addr_ok;

  assign rsp_live   = inst_data_ok && (discard == '0) && !redirect_valid;
  assign fifo_empty = (count == '0);
`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && rsp_live;
`else
  assign bypass = 1'b0;
`endif
  assign out_valid = !fifo_empty || bypass;
  assign pop       = !fifo_empty && out_ready && !redirect_valid;
  assign data_push = rsp_live && !(bypass && out_ready);
  // live == 0 guarantees no response can push in the same cycle.
  assign adel_push = (state == S_ADEL_WAIT) && !redirect_valid && (live == '0) &&
                     (count < CW'(DEPTH));
  assign push      = data_push || adel_push;
  assign push_pc   = adel_push ? pc : tag_q[tag_rd];
  assign push_inst = adel_push ? '0 : inst_rdata;
  assign occupancy = count;

  assign outstanding_nxt = outstanding + OW'(accept) - OW'(inst_data_ok);

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    out_adel = 1'b0;
    if (!fifo_empty) begin
      out_inst = mem_inst[rd_ptr];
      out_pc   = mem_pc[rd_ptr];
      out_adel = mem_adel[rd_ptr];
    end else if (bypass) begin
      out_inst = inst_rdata;
      out_pc   = tag_q[tag_rd];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (accept)       tag_wr <= tag_next(tag_wr);
      // Discarded responses still retire their tag so the queue stays aligned.
      if (inst_data_ok) tag_rd <= tag_next(tag_rd);
      if (redirect_valid) begin
        pc      <= redirect_pc;
        state   <= (redirect_pc[1:0] != 2'b00) ? S_ADEL_WAIT : S_FETCH;
        discard <= outstanding_nxt;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end else begin
        if (accept) pc <= pc + ADDR_W'(4);
        if (inst_data_ok && (discard != '0)) discard <= discard - OW'(1);
        if (adel_push) state <= S_IDLE;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr] <= pc;
    if (push) begin
      mem_inst[wr_ptr] <= push_inst;
      mem_pc[wr_ptr]   <= push_pc;
      mem_adel[wr_ptr] <= adel_push;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model plus expected-entry scoreboard.
`timescale 1ns/1ps
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 8;
  localparam int          MAXO     = 4;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_adel;
  logic [3:0]  occupancy;

  inst_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ADDR_W(32), .DATA_W(32),
                     .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_adel(out_adel),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit stale; } req_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic adel; } ent_t;

  req_t        pend[$];
  ent_t        sb[$];
  int          errors = 0, checks = 0;
  int          cyc, lat, n_acc, n_pop;
  bit          rand_aok;
  logic [31:0] exp_pc, first_pop_pc, prev_addr;
  logic        prev_wait, s_valid, s_req;
  logic [3:0]  s_occ;
  int          s_outst;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hdeadbeef;
  endfunction

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic step();
    bit   rsp;
    req_t r;
    ent_t e;
    rsp = 1'b0;
    inst_addr_ok = rand_aok ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp = 1'b1;
      r = pend.pop_front();
    end
    inst_data_ok = rsp;
    inst_rdata   = rsp ? r.data : $urandom();
    #1;
    s_outst = pend.size() + (rsp ? 1 : 0);
    s_valid = out_valid;
    s_req   = inst_req;
    s_occ   = occupancy;
    if (redirect_valid) begin
      checks++;
      if (inst_req !== 1'b0) begin errors++; $display("FAIL req_in_redirect: got %b expected 0", inst_req); end
      foreach (pend[i]) pend[i].stale = 1'b1;
      sb.delete();
      exp_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) sb.push_back('{pc: redirect_pc, inst: 32'h0, adel: 1'b1});
    end else if (prev_wait) begin
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin
        errors++;
        $display("FAIL req_stable: got req=%b addr=%h expected req=1 addr=%h", inst_req, inst_addr, prev_addr);
      end
    end
    if (s_outst >= MAXO) begin
      checks++;
      if (inst_req !== 1'b0) begin errors++; $display("FAIL max_outstanding: got req=%b with %0d in flight expected 0", inst_req, s_outst); end
    end
    if (rsp && !r.stale && !redirect_valid) begin
      checks++;
      if (occupancy == 4'(DEPTH) && !(out_valid && out_ready)) begin
        errors++;
        $display("FAIL push_full: got occupancy=%0d expected below %0d", occupancy, DEPTH);
      end
      sb.push_back('{pc: r.addr, inst: r.data, adel: 1'b0});
    end
    if (inst_req && inst_addr_ok) begin
      checks++;
      if (inst_addr !== exp_pc) begin errors++; $display("FAIL fetch_addr: got %h expected %h", inst_addr, exp_pc); end
      pend.push_back('{addr: exp_pc, data: mem_data(exp_pc), due: cyc + lat, stale: 1'b0});
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (out_valid && out_ready && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got pc=%h expected no entry", out_pc);
      end else begin
        e = sb.pop_front();
        if ({out_pc, out_inst, out_adel} !== e) begin
          errors++;
          $display("FAIL out_entry: got pc=%h inst=%h adel=%b expected pc=%h inst=%h adel=%b",
                   out_pc, out_inst, out_adel, e.pc, e.inst, e.adel);
        end
      end
      if (n_pop == 0) first_pop_pc = out_pc;
      n_pop++;
    end
    prev_wait = inst_req && !inst_addr_ok && !redirect_valid;
    prev_addr = inst_addr;
    @(posedge clk);
    @(negedge clk);
    inst_data_ok = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input int latency);
    reset = 1'b1;
    redirect_valid = 1'b0;
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    rand_aok = 1'b0;
    pend.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lat = latency;
    cyc = 0; n_acc = 0; n_pop = 0;
    prev_wait = 1'b0;
    exp_pc = RESET_PC;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (inst_req !== 1'b0)     begin errors++; $display("FAIL rst_req: got %b expected 0", inst_req); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (out_inst !== 32'h0)    begin errors++; $display("FAIL rst_inst: got %h expected 0", out_inst); end
    checks++; if (out_pc !== 32'h0)      begin errors++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
    checks++; if (out_adel !== 1'b0)     begin errors++; $display("FAIL rst_adel: got %b expected 0", out_adel); end
    checks++; if (occupancy !== 4'd0)    begin errors++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
    checks++; if (inst_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", inst_addr, RESET_PC); end
    // Fill part of the FIFO, then reset between clock edges.
    do_reset(1);
    out_ready = 1'b0;
    repeat (5) step();
    #1;
    checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL pre_rst_occ: got %0d expected 4", occupancy); end
    reset = 1'b1;
    #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL async_rst_occ: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_sequential();
    do_reset(1);
    out_ready = 1'b1;
    repeat (20) step();
    #1;
    checks++; if (inst_addr !== RESET_PC + 32'd80) begin errors++; $display("FAIL seq_addr: got %h expected %h", inst_addr, RESET_PC + 32'd80); end
    checks++; if (n_pop !== (BYP ? 19 : 18)) begin errors++; $display("FAIL seq_pops: got %0d expected %0d", n_pop, BYP ? 19 : 18); end
    checks++; if (first_pop_pc !== RESET_PC) begin errors++; $display("FAIL seq_first_pc: got %h expected %h", first_pop_pc, RESET_PC); end
  endtask

  task automatic test_full();
    do_reset(1);
    out_ready = 1'b0;
    repeat (20) step();
    #1;
    checks++; if (n_acc !== 8)         begin errors++; $display("FAIL full_accepts: got %0d expected 8", n_acc); end
    checks++; if (occupancy !== 4'd8)  begin errors++; $display("FAIL full_occ: got %0d expected 8", occupancy); end
    checks++; if (inst_req !== 1'b0)   begin errors++; $display("FAIL full_req: got %b expected 0", inst_req); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (10) step();
    #1;
    checks++; if (n_acc !== 9)         begin errors++; $display("FAIL refill_accepts: got %0d expected 9", n_acc); end
    checks++; if (occupancy !== 4'd8)  begin errors++; $display("FAIL refill_occ: got %0d expected 8", occupancy); end
  endtask

  task automatic test_max_outstanding();
    int hit_max;
    hit_max = 0;
    do_reset(5);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_outst == MAXO) hit_max++;
    end
    checks++; if (hit_max == 0) begin errors++; $display("FAIL max_reached: got %0d cycles at limit expected nonzero", hit_max); end
    checks++; if (n_pop < 20)   begin errors++; $display("FAIL max_pops: got %0d expected at least 20", n_pop); end
  endtask

  task automatic test_latency();
    do_reset(3);
    out_ready = 1'b1;
    repeat (3) step();
    step();
    checks++; if (s_valid !== BYP)  begin errors++; $display("FAIL lat_same_cycle: got %b expected %b", s_valid, BYP); end
    checks++; if (s_occ !== 4'd0)   begin errors++; $display("FAIL lat_occ0: got %0d expected 0", s_occ); end
    step();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL lat_next_cycle: got %b expected 1", s_valid); end
    checks++; if (s_occ !== (BYP ? 4'd0 : 4'd1)) begin errors++; $display("FAIL lat_occ1: got %0d expected %0d", s_occ, BYP ? 0 : 1); end
  endtask

  task automatic test_redirect();
    do_reset(3);
    out_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80001000;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (s_occ !== 4'd0)   begin errors++; $display("FAIL redir_occ: got %0d expected 0", s_occ); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", s_valid); end
    repeat (10) step();
    checks++; if (n_pop == 0) begin errors++; $display("FAIL redir_pops: got 0 expected nonzero"); end
    checks++; if (first_pop_pc !== 32'h80001000) begin errors++; $display("FAIL redir_first_pc: got %h expected 80001000", first_pop_pc); end
  endtask

  task automatic test_adel();
    do_reset(2);
    out_ready = 1'b0;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80001002;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL adel_req: got %b expected 0", s_req); end
    end
    #1;
    checks++; if (occupancy !== 4'd1)      begin errors++; $display("FAIL adel_occ: got %0d expected 1", occupancy); end
    checks++; if (out_adel !== 1'b1)       begin errors++; $display("FAIL adel_flag: got %b expected 1", out_adel); end
    checks++; if (out_pc !== 32'h80001002) begin errors++; $display("FAIL adel_pc: got %h expected 80001002", out_pc); end
    checks++; if (out_inst !== 32'h0)      begin errors++; $display("FAIL adel_inst: got %h expected 0", out_inst); end
    out_ready = 1'b1;
    repeat (4) step();
    #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL adel_drain: got %0d expected 0", occupancy); end
    checks++; if (inst_req !== 1'b0)  begin errors++; $display("FAIL adel_idle: got %b expected 0", inst_req); end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    rand_aok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom() & 32'hfffffffc;
      end
      step();
      redirect_valid = 1'b0;
    end
    checks++; if (n_pop < 50) begin errors++; $display("FAIL b2b_pops: got %0d expected at least 50", n_pop); end
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    out_ready = 1'b0;
    rand_aok = 1'b0;
    prev_wait = 1'b0;
    first_pop_pc = 32'h0;
    test_reset();
    test_sequential();
    test_full();
    test_max_outstanding();
    test_latency();
    test_redirect();
    test_adel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
